matprod_stage_sequencer: RTL and testbench
==========================================

# matprod_stage_sequencer

Top-level controller for the matprod accelerator. It runs the four ap_ctrl_hs sub-kernels (load A, load B, multiply-accumulate loop, store) strictly in order, one invocation per run. It drives each stage's ap_start, consumes its ap_ready/ap_done, and reports run-level handshakes to the host. Optionally it keeps per-stage cycle counts for performance profiling.

## Interface
- NUM_STAGES, 4: number of sequenced sub-kernels; stage 0 runs first.
- CNT_W, 32: width of each profiling counter.

- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request, level, held until `ready`.
- skip_mask  in  NUM_STAGES  bit k=1 skips stage k; sampled at acceptance.
- ready  out  1  one-cycle pulse, run accepted.
- done  out  1  one-cycle pulse, run complete.
- idle  out  1  high in IDLE.
- proto_err  out  1  sticky; `stage_done[j]` seen while j is not the active stage.
- stage_start  out  NUM_STAGES  per-stage ap_start; at most one bit high.
- stage_ready  in  NUM_STAGES  per-stage ap_ready.
- stage_done  in  NUM_STAGES  per-stage ap_done, one-cycle pulse.
- stage_cycles  out  NUM_STAGES*CNT_W  per-stage cycle counts, stage k at bits [k*CNT_W +: CNT_W].

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, FINISH.
- IDLE, start=1: latch skip_mask, clear proto_err, pulse `ready` the next cycle.
  - If an unskipped stage exists, go to LAUNCH with cur = lowest unskipped index.
  - If all stages are skipped, go to FINISH.
- LAUNCH: stage_start[cur]=1.
  - stage_ready[cur]=1 and stage_done[cur]=1 in the same cycle: advance.
  - stage_ready[cur]=1 only: go to WAIT_DONE, stage_start drops the next cycle.
  - stage_ready[cur]=0: stay in LAUNCH.
- WAIT_DONE: stage_start all zero. stage_done[cur]=1 advances.
- Advance:
  - next = lowest unskipped index greater than cur.
  - If next exists, go to LAUNCH(next).
  - If none, go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- proto_err is set by stage_done[j] for any j other than cur during LAUNCH or WAIT_DONE, and by any stage_done in IDLE or FINISH. The sequencer ignores that pulse otherwise.
- start during a run is ignored. A held start after `done` begins a new run from IDLE.

## Timing
- Reset values: ready=0, done=0, idle=1, proto_err=0, stage_start=0, stage_cycles=0, state=IDLE.
- Reset mid-run takes effect immediately (async): stage_start drops without waiting for stage handshakes, and the latched skip_mask and cur are discarded.
- start sampled high at edge t: ready=1 and stage_start[first]=1 during cycle t+1.
- stage_done[k] sampled at edge t: stage_start[next]=1 during cycle t+1. This is a one-cycle gap between stages.
- Last stage_done sampled at edge t: done=1 during cycle t+1, idle=1 during cycle t+2.
- All stages skipped, start at edge t: ready=1 in t+1 and done=1 in t+2.
- ready and done may not be high in the same cycle; with all stages skipped they fall in consecutive cycles.

## Configuration
- STAGE_PROFILE_EN defined:
  - Each stage k has a CNT_W counter, cleared when the run is accepted.
  - It increments every cycle that stage k is cur in LAUNCH or WAIT_DONE, including the cycle stage_done is sampled.
  - It saturates at 2^CNT_W-1 and holds its value until the next acceptance.
  - Skipped stages read 0.
- STAGE_PROFILE_EN undefined: no counter logic; stage_cycles is tied to 0.

## Test plan
- Basic run: skip_mask=0. Each stage asserts ready on the first start cycle and done 10 cycles later. Expect:
  - four stage_start windows in order 0,1,2,3;
  - done 1 cycle after stage 3 done;
  - profiled stage_cycles = 11 each.
- Same-cycle ready/done: stage 2 asserts ready and done together on its first start cycle. Expect stage_start[2] high exactly 1 cycle, stage_start[3] the next cycle, and stage_cycles[2]=1.
- Skips: skip_mask=4'b0110. Expect only stages 0 and 3 started, and stage_cycles[1]=stage_cycles[2]=0. With skip_mask=4'b1111, expect ready at t+1 and done at t+2.
- Ready stall: stage 1 holds ready low for 5 cycles. Expect stage_start[1] held for 6 cycles and no other stage_start bit high.
- Protocol error: pulse stage_done[3] while stage 0 is active. Expect proto_err=1 and sequencing unchanged. proto_err clears at the next acceptance.
- Reset mid-run: assert reset during stage 2 WAIT_DONE. Expect all outputs at reset values immediately. A new start then runs cleanly from stage 0.

Source files
------------

// File: rtl/matprod_stage_sequencer.sv
// Sequences the four ap_ctrl_hs matprod sub-kernels strictly in order, one invocation each per run.
// Define STAGE_PROFILE_EN to build the per-stage saturating cycle counters.
module matprod_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [NUM_STAGES-1:0]       skip_mask_i,
  output logic                        ready_o,
  output logic                        done_o,
  output logic                        idle_o,
  output logic                        proto_err_o,
  output logic [NUM_STAGES-1:0]       stage_start_o,
  input  logic [NUM_STAGES-1:0]       stage_ready_i,
  input  logic [NUM_STAGES-1:0]       stage_done_i,
  output logic [NUM_STAGES*CNT_W-1:0] stage_cycles_o
);

  localparam int CUR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_FINISH} state_e;

  state_e                state_q, state_d;
  logic [CUR_W-1:0]      cur_q, cur_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic                  ready_q, ready_d;
  logic                  proto_q, proto_d;

  logic                  first_vld, next_vld, advance;
  logic [CUR_W-1:0]      first_idx, next_idx;
  logic [NUM_STAGES-1:0] active;

  // Downward scans so the last hit is the lowest qualifying index.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (!skip_mask_i[k]) begin
        first_vld = 1'b1;
        first_idx = CUR_W'(k);
      end
      if (!skip_q[k] && (k > int'(cur_q))) begin
        next_vld = 1'b1;
        next_idx = CUR_W'(k);
      end
    end
  end

  assign active = ((state_q == S_LAUNCH) || (state_q == S_WAIT_DONE)) ?
                  (NUM_STAGES'(1) << cur_q) : '0;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    skip_d  = skip_q;
    ready_d = 1'b0;
    proto_d = proto_q | (|(stage_done_i & ~active));
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ready_d = 1'b1;
          skip_d  = skip_mask_i;
          proto_d = 1'b0;
          if (first_vld) begin
            state_d = S_LAUNCH;
            cur_d   = first_idx;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_LAUNCH: begin
        if (stage_ready_i[cur_q]) begin
          if (stage_done_i[cur_q]) advance = 1'b1;
          else                     state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (stage_done_i[cur_q]) advance = 1'b1;
      end
      S_FINISH: begin
        // An all-skipped run lands here while ready is still pulsing; hold one
        // extra cycle so done never coincides with ready.
        if (!ready_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (next_vld) begin
        state_d = S_LAUNCH;
        cur_d   = next_idx;
      end else begin
        state_d = S_FINISH;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      skip_q  <= '0;
      ready_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      skip_q  <= skip_d;
      ready_q <= ready_d;
      proto_q <= proto_d;
    end
  end

  assign ready_o       = ready_q;
  assign done_o        = (state_q == S_FINISH) && !ready_q;
  assign idle_o        = (state_q == S_IDLE);
  assign proto_err_o   = proto_q;
  assign stage_start_o = (state_q == S_LAUNCH) ? (NUM_STAGES'(1) << cur_q) : '0;

`ifdef STAGE_PROFILE_EN
  logic accept;
  assign accept = (state_q == S_IDLE) && start_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_prof
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                             cnt_q <= '0;
      else if (accept)                       cnt_q <= '0;
      else if (active[k] && (cnt_q != '1))   cnt_q <= cnt_q + 1'b1;
    end
    assign stage_cycles_o[k*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign stage_cycles_o = '0;
`endif

endmodule

// File: tb/tb_matprod_stage_sequencer.sv
// Directed bench for matprod_stage_sequencer: per-stage ap_ctrl_hs responder model plus
// cycle-stamped monitor, all stepped from one process on the falling edge.
module tb_matprod_stage_sequencer;
  localparam int NS = 4;
  localparam int CW = 32;
`ifdef STAGE_PROFILE_EN
  localparam bit PROF = 1'b1;
`else
  localparam bit PROF = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [NS-1:0]   skip_mask_i;
  logic            ready_o, done_o, idle_o, proto_err_o;
  logic [NS-1:0]   stage_start_o, stage_ready_i, stage_done_i;
  logic [NS*CW-1:0] stage_cycles_o;

  matprod_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .skip_mask_i(skip_mask_i),
    .ready_o(ready_o), .done_o(done_o), .idle_o(idle_o), .proto_err_o(proto_err_o),
    .stage_start_o(stage_start_o), .stage_ready_i(stage_ready_i),
    .stage_done_i(stage_done_i), .stage_cycles_o(stage_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0, cyc = 0;
  int rdly[NS], ddly[NS], mcnt[NS], start_cnt[NS], first_start[NS], done_in[NS];
  bit busy[NS];
  logic [NS-1:0] prev_start;
  int ready_cyc, done_cyc, ready_n, multi_err, rd_overlap, nord;
  logic [15:0] ord;
  bit hold_start = 1'b0;

  function automatic logic [CW-1:0] cyc_of(input int k);
    return stage_cycles_o[k*CW +: CW];
  endfunction

  task automatic clr_log();
    ready_cyc = -1; done_cyc = -1; ready_n = 0; multi_err = 0; rd_overlap = 0;
    nord = 0; ord = '0;
    for (int k = 0; k < NS; k++) begin
      start_cnt[k] = 0; first_start[k] = -1; done_in[k] = -1;
    end
  endtask

  task automatic set_delays(input int rd, input int dd);
    for (int k = 0; k < NS; k++) begin rdly[k] = rd; ddly[k] = dd; end
  endtask

  // One falling edge: log DUT outputs, then drive the stage responses for the next rising edge.
  task automatic tick();
    logic [NS-1:0] mr, md;
    @(negedge clk_i);
    cyc++;
    if (ready_o) begin ready_cyc = cyc; ready_n++; if (!hold_start) start_i = 1'b0; end
    if (done_o) done_cyc = cyc;
    if (ready_o && done_o) rd_overlap++;
    if ($countones(stage_start_o) > 1) multi_err++;
    for (int k = 0; k < NS; k++) begin
      if (stage_start_o[k]) begin
        start_cnt[k]++;
        if (!prev_start[k]) begin
          first_start[k] = cyc; ord = {ord[11:0], 4'(k)}; nord++;
        end
      end
    end
    prev_start = stage_start_o;
    mr = '0; md = '0;
    for (int k = 0; k < NS; k++) begin
      if (rst_i) busy[k] = 1'b0;
      else begin
        if (!busy[k] && stage_start_o[k]) begin busy[k] = 1'b1; mcnt[k] = 0; end
        if (busy[k]) begin
          if (mcnt[k] == rdly[k] && stage_start_o[k]) mr[k] = 1'b1;
          if (mcnt[k] == rdly[k] + ddly[k]) begin
            md[k] = 1'b1; busy[k] = 1'b0; done_in[k] = cyc;
          end
          mcnt[k]++;
        end
      end
    end
    stage_ready_i = mr;
    stage_done_i  = md;
  endtask

  task automatic launch(input logic [NS-1:0] m, output int c0, output bit to);
    skip_mask_i = m; start_i = 1'b1; c0 = cyc; to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!start_i) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cyc >= 0) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; skip_mask_i = '0; stage_ready_i = '0; stage_done_i = '0;
    prev_start = '0; set_delays(0, 0);
    for (int k = 0; k < NS; k++) begin busy[k] = 1'b0; mcnt[k] = 0; end
    clr_log();
    tick(); tick();
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done_o); end
    tests++; if (idle_o !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle_o); end
    tests++; if (proto_err_o !== 1'b0) begin fails++; $display("FAIL reset_proto got %b exp 0", proto_err_o); end
    tests++; if (stage_start_o !== 4'b0) begin fails++; $display("FAIL reset_start got %b exp 0000", stage_start_o); end
    tests++; if (stage_cycles_o !== '0) begin fails++; $display("FAIL reset_cycles got %h exp 0", stage_cycles_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c0; bit to;
    clr_log(); set_delays(0, 10);
    launch(4'b0000, c0, to);
    wait_done(200, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout got no done exp done"); end
    tests++; if (ready_cyc !== c0 + 1) begin fails++; $display("FAIL basic_ready_cyc got %0d exp %0d", ready_cyc, c0 + 1); end
    tests++; if (first_start[0] !== c0 + 1) begin fails++; $display("FAIL basic_first_start got %0d exp %0d", first_start[0], c0 + 1); end
    tests++; if (ord !== 16'h0123 || nord !== 4) begin fails++; $display("FAIL basic_order got %h/%0d exp 0123/4", ord, nord); end
    tests++; if (first_start[1] !== done_in[0] + 1) begin fails++; $display("FAIL basic_gap got %0d exp %0d", first_start[1], done_in[0] + 1); end
    tests++; if (done_cyc !== done_in[3] + 1) begin fails++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, done_in[3] + 1); end
    for (int k = 0; k < NS; k++) begin
      tests++; if (start_cnt[k] !== 1) begin fails++; $display("FAIL basic_start_len%0d got %0d exp 1", k, start_cnt[k]); end
      tests++; if (cyc_of(k) !== 32'(PROF ? 11 : 0)) begin fails++; $display("FAIL basic_cycles%0d got %0d exp %0d", k, cyc_of(k), PROF ? 11 : 0); end
    end
    tick();
    tests++; if (idle_o !== 1'b1) begin fails++; $display("FAIL basic_idle_after got %b exp 1", idle_o); end
    tests++; if (multi_err !== 0 || rd_overlap !== 0) begin fails++; $display("FAIL basic_exclusive got %0d/%0d exp 0/0", multi_err, rd_overlap); end
  endtask

  task automatic test_same_cycle();
    int c0; bit to;
    clr_log(); set_delays(0, 10); ddly[2] = 0;
    launch(4'b0000, c0, to);
    wait_done(200, to);
    tests++; if (to) begin fails++; $display("FAIL same_timeout got no done exp done"); end
    tests++; if (start_cnt[2] !== 1) begin fails++; $display("FAIL same_start2_len got %0d exp 1", start_cnt[2]); end
    tests++; if (first_start[3] !== first_start[2] + 1) begin fails++; $display("FAIL same_start3_cyc got %0d exp %0d", first_start[3], first_start[2] + 1); end
    tests++; if (cyc_of(2) !== 32'(PROF ? 1 : 0)) begin fails++; $display("FAIL same_cycles2 got %0d exp %0d", cyc_of(2), PROF ? 1 : 0); end
    tick();
  endtask

  task automatic test_skips();
    int c0; bit to;
    clr_log(); set_delays(0, 3);
    launch(4'b0110, c0, to);
    wait_done(100, to);
    tests++; if (to) begin fails++; $display("FAIL skip_timeout got no done exp done"); end
    tests++; if (ord !== 16'h0003 || nord !== 2) begin fails++; $display("FAIL skip_order got %h/%0d exp 0003/2", ord, nord); end
    tests++; if (cyc_of(0) !== 32'(PROF ? 4 : 0)) begin fails++; $display("FAIL skip_cycles0 got %0d exp %0d", cyc_of(0), PROF ? 4 : 0); end
    tests++; if (cyc_of(1) !== 32'd0 || cyc_of(2) !== 32'd0) begin fails++; $display("FAIL skip_cycles12 got %0d/%0d exp 0/0", cyc_of(1), cyc_of(2)); end
    tick();
    clr_log();
    launch(4'b1111, c0, to);
    wait_done(20, to);
    tests++; if (ready_cyc !== c0 + 1) begin fails++; $display("FAIL allskip_ready got %0d exp %0d", ready_cyc, c0 + 1); end
    tests++; if (done_cyc !== c0 + 2) begin fails++; $display("FAIL allskip_done got %0d exp %0d", done_cyc, c0 + 2); end
    tests++; if (nord !== 0 || rd_overlap !== 0) begin fails++; $display("FAIL allskip_quiet got %0d/%0d exp 0/0", nord, rd_overlap); end
    tick();
  endtask

  task automatic test_ready_stall();
    int c0; bit to;
    clr_log(); set_delays(0, 2); rdly[1] = 5;
    launch(4'b0000, c0, to);
    wait_done(100, to);
    tests++; if (to) begin fails++; $display("FAIL stall_timeout got no done exp done"); end
    tests++; if (start_cnt[1] !== 6) begin fails++; $display("FAIL stall_start1_len got %0d exp 6", start_cnt[1]); end
    tests++; if (multi_err !== 0 || ord !== 16'h0123) begin fails++; $display("FAIL stall_exclusive got %0d/%h exp 0/0123", multi_err, ord); end
    tests++; if (cyc_of(1) !== 32'(PROF ? 8 : 0)) begin fails++; $display("FAIL stall_cycles1 got %0d exp %0d", cyc_of(1), PROF ? 8 : 0); end
    tick();
  endtask

  task automatic test_proto_err();
    int c0; bit to;
    clr_log(); set_delays(0, 10);
    launch(4'b0000, c0, to);
    stage_done_i = stage_done_i | 4'b1000;
    tick();
    tests++; if (proto_err_o !== 1'b1) begin fails++; $display("FAIL proto_set got %b exp 1", proto_err_o); end
    wait_done(200, to);
    tests++; if (to || ord !== 16'h0123) begin fails++; $display("FAIL proto_seq got %h to=%0d exp 0123", ord, to); end
    tests++; if (cyc_of(0) !== 32'(PROF ? 11 : 0)) begin fails++; $display("FAIL proto_cycles0 got %0d exp %0d", cyc_of(0), PROF ? 11 : 0); end
    tests++; if (proto_err_o !== 1'b1) begin fails++; $display("FAIL proto_sticky got %b exp 1", proto_err_o); end
    tick();
    clr_log();
    launch(4'b0000, c0, to);
    tests++; if (proto_err_o !== 1'b0) begin fails++; $display("FAIL proto_clear got %b exp 0", proto_err_o); end
    wait_done(200, to);
    tick();
    stage_done_i = 4'b0010;
    tick();
    tests++; if (proto_err_o !== 1'b1) begin fails++; $display("FAIL proto_idle got %b exp 1", proto_err_o); end
  endtask

  task automatic test_reset_mid();
    int c0; bit to;
    clr_log(); set_delays(0, 10);
    launch(4'b0000, c0, to);
    for (int i = 0; i < 100 && first_start[2] < 0; i++) tick();
    tick(); tick(); tick();
    rst_i = 1'b1;
    #1;
    tests++; if (stage_start_o !== 4'b0 || idle_o !== 1'b1) begin fails++; $display("FAIL rstmid_start_idle got %b/%b exp 0000/1", stage_start_o, idle_o); end
    tests++; if (ready_o !== 1'b0 || done_o !== 1'b0 || proto_err_o !== 1'b0) begin fails++; $display("FAIL rstmid_flags got %b%b%b exp 000", ready_o, done_o, proto_err_o); end
    tests++; if (stage_cycles_o !== '0) begin fails++; $display("FAIL rstmid_cycles got %h exp 0", stage_cycles_o); end
    tick(); tick();
    rst_i = 1'b0;
    tick();
    clr_log();
    launch(4'b0000, c0, to);
    wait_done(200, to);
    tests++; if (to || ord !== 16'h0123 || first_start[0] !== c0 + 1) begin fails++; $display("FAIL rstmid_rerun got %h@%0d exp 0123@%0d", ord, first_start[0], c0 + 1); end
    tests++; if (cyc_of(2) !== 32'(PROF ? 11 : 0)) begin fails++; $display("FAIL rstmid_cycles2 got %0d exp %0d", cyc_of(2), PROF ? 11 : 0); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    clr_log(); hold_start = 1'b1;
    skip_mask_i = 4'b1111; start_i = 1'b1; c0 = cyc;
    for (int i = 0; i < 20 && ready_n < 2; i++) tick();
    hold_start = 1'b0; start_i = 1'b0;
    tests++; if (ready_n !== 2 || ready_cyc !== c0 + 4) begin fails++; $display("FAIL b2b_second_ready got %0d@%0d exp 2@%0d", ready_n, ready_cyc, c0 + 4); end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (idle_o !== 1'b1 || rd_overlap !== 0) begin fails++; $display("FAIL b2b_idle got %b/%0d exp 1/0", idle_o, rd_overlap); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_skips();
    test_ready_stall();
    test_proto_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
